// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the SRAM responder.
// Holds A/D opcode constants, the D-channel payload struct and an
// address-alignment helper.
package tl_pkg;

  localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_A_GET           = 3'd4;
  localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;

  localparam int unsigned TL_DATA_W       = 64;
  localparam int unsigned TL_MASK_W       = 8;
  // Source field is sized for the widest supported ID; narrower IDs are zero-extended.
  localparam int unsigned TL_SOURCE_MAX_W = 16;

  typedef struct packed {
    logic [2:0]                 opcode;
    logic [2:0]                 size;
    logic [TL_SOURCE_MAX_W-1:0] source;
    logic                       denied;
    logic [TL_DATA_W-1:0]       data;
    logic                       corrupt;
  } tl_d_bits_t;

  // True when the low address bits are aligned to 2^size (size 0..3 only).
  function automatic logic addr_aligned(input logic [2:0] size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (addr_lo[0] == 1'b0);
      3'd2:    ok = (addr_lo[1:0] == 2'b00);
      3'd3:    ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_d_resp_reg.sv
// One-entry D-channel holding register with ready/valid handshake.
// The slot can be refilled in the same cycle it drains.
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   in_valid/in_ready_c/in_bits   load side (in_ready_c is combinational)
//   out_valid/out_ready/out_bits  D side, registered
module tl_d_resp_reg
  import tl_pkg::*;
#(
  parameter int unsigned SOURCE_W = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready_c,
  input  tl_d_bits_t in_bits,
  output logic       out_valid,
  input  logic       out_ready,
  output tl_d_bits_t out_bits
);

  logic load;

  assign in_ready_c = !out_valid || out_ready;
  assign load       = in_valid && in_ready_c;

  // Holding register: load replaces, drain without load empties.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_bits  <= '0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_bits        <= in_bits;
      out_bits.source <= TL_SOURCE_MAX_W'(in_bits.source[SOURCE_W-1:0]);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tl_sram_responder.sv
// Single-beat TileLink-UL responder terminating an A/D channel pair at a
// local 64-bit word memory. Supports Get, PutFullData, PutPartialData;
// anything else, or an illegal address/size, is answered with d_denied.
// Optional macro TL_SRAM_PROT_CHECK_EN: when defined, Puts with
// a_prot_privileged=0 are denied and do not write.
// Ports:
//   clock, reset            clock and asynchronous active-low reset
//   a_*                     TL A channel (request in), a_ready combinational
//   d_*                     TL D channel (response out), registered
module tl_sram_responder
  import tl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned SOURCE_W  = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic                a_prot_privileged,
  input  logic [7:0]          a_mask,
  input  logic [63:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [63:0]         d_data,
  output logic                d_corrupt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 8);

  logic [TL_DATA_W-1:0] mem [DEPTH];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             size_ok;
  logic             aligned;
  logic             op_get;
  logic             op_put;
  logic             base_ok;
  logic             prot_ok;
  logic             legal_get;
  logic             legal_put;
  logic             a_fire;
  logic             wr_en;
  logic [63:0]      rdata;
  tl_d_bits_t       resp;
  tl_d_bits_t       d_bits;
  logic             unused_ok;

  // Address decode: offset compare avoids overflow of BASE_ADDR + span.
  assign offset   = a_address - BASE_ADDR;
  assign idx      = offset[IDX_W+2:3];
  assign in_range = (a_address >= BASE_ADDR) && (offset < SPAN);
  assign size_ok  = (a_size <= 3'd3);
  assign aligned  = addr_aligned(a_size, a_address[2:0]);
  assign op_get   = (a_opcode == TL_A_GET);
  assign op_put   = (a_opcode == TL_A_PUTFULL) || (a_opcode == TL_A_PUTPARTIAL);
  assign base_ok  = in_range && size_ok && aligned;

`ifdef TL_SRAM_PROT_CHECK_EN
  assign prot_ok   = a_prot_privileged;
  assign unused_ok = &{1'b0, offset[2:0]};
`else
  assign prot_ok   = 1'b1;
  assign unused_ok = &{1'b0, offset[2:0], a_prot_privileged};
`endif

  assign legal_get = base_ok && op_get;
  assign legal_put = base_ok && op_put && prot_ok;
  assign a_fire    = a_valid && a_ready;
  assign wr_en     = a_fire && legal_put;
  assign rdata     = mem[idx];

  // Byte-lane write; commits at the Put's fire edge so a following Get sees it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (a_mask[i]) begin
          mem[idx][8*i +: 8] <= a_data[8*i +: 8];
        end
      end
    end
  end

  // Response payload for the current A request.
  always_comb begin
    resp        = '0;
    resp.size   = a_size;
    resp.source = TL_SOURCE_MAX_W'(a_source);
    if (op_get) begin
      resp.opcode = TL_D_ACCESSACKDATA;
      if (legal_get) begin
        resp.data = rdata;
      end else begin
        resp.denied  = 1'b1;
        resp.corrupt = 1'b1;
      end
    end else begin
      resp.opcode = TL_D_ACCESSACK;
      resp.denied = !legal_put;
    end
  end

  tl_d_resp_reg #(
    .SOURCE_W (SOURCE_W)
  ) u_d_reg (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (a_valid),
    .in_ready_c (a_ready),
    .in_bits    (resp),
    .out_valid  (d_valid),
    .out_ready  (d_ready),
    .out_bits   (d_bits)
  );

  assign d_opcode  = d_bits.opcode;
  assign d_size    = d_bits.size;
  assign d_source  = SOURCE_W'(d_bits.source);
  assign d_denied  = d_bits.denied;
  assign d_data    = d_bits.data;
  assign d_corrupt = d_bits.corrupt;

endmodule

// File: tb/tb_tl_sram_responder.sv
// Scoreboard bench for tl_sram_responder: stimulus pushes expected
// responses, a negedge monitor pops and compares on each D fire.
module tb_tl_sram_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned SW = 7;
  localparam logic [31:0] A = BASE + 32'h10;
  localparam logic [31:0] TOP = BASE + 32'h7F8;
  localparam logic [31:0] OUTR = BASE + 32'h800;
  localparam logic [2:0] PF = 3'd0, PP = 3'd1, GT = 3'd4, AR = 3'd2;
  localparam logic [2:0] ACK = 3'd0, ACKD = 3'd1;

  logic          clock, reset;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode, a_size;
  logic [SW-1:0] a_source;
  logic [31:0]   a_address;
  logic          a_prot_privileged;
  logic [7:0]    a_mask;
  logic [63:0]   a_data;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode, d_size;
  logic [SW-1:0] d_source;
  logic          d_denied, d_corrupt;
  logic [63:0]   d_data;

  tl_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .SOURCE_W(SW)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_prot_privileged(a_prot_privileged),
    .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt)
  );

  typedef struct packed {
    logic [2:0]    op;
    logic [2:0]    size;
    logic [SW-1:0] src;
    logic          den;
    logic          cor;
    logic [63:0]   data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   dv_cycles = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every response at the cycle it is accepted.
  always @(negedge clock) begin
    if (reset && d_valid) dv_cycles++;
    if (reset && d_valid && d_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got source %0d want no response", d_source);
      end else begin
        mon_e = q.pop_front();
        chk("d_opcode",  64'(d_opcode),  64'(mon_e.op));
        chk("d_size",    64'(d_size),    64'(mon_e.size));
        chk("d_source",  64'(d_source),  64'(mon_e.src));
        chk("d_denied",  64'(d_denied),  64'(mon_e.den));
        chk("d_corrupt", 64'(d_corrupt), 64'(mon_e.cor));
        chk("d_data",    d_data,         mon_e.data);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [2:0] sz, input int src,
                       input logic [31:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic priv);
    a_opcode = op; a_size = sz; a_source = SW'(src); a_address = addr;
    a_mask = mask; a_data = data; a_prot_privileged = priv; a_valid = 1'b1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] sz, input int src,
                       input logic [31:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic priv,
                       input logic [2:0] eop, input logic eden, input logic ecor,
                       input logic [63:0] edata);
    exp_t e;
    int n;
    drive(op, sz, src, addr, mask, data, priv);
    n = 0;
    @(negedge clock);
    while (!a_ready && n < 20) begin
      n++;
      @(negedge clock);
    end
    if (!a_ready) begin
      total++;
      bad++;
      $display("FAIL a_ready_timeout: got 0 want 1");
    end else begin
      e.op = eop; e.size = sz; e.src = SW'(src); e.den = eden; e.cor = ecor; e.data = edata;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dv0;
    reset = 1'b0; d_ready = 1'b1;
    a_valid = 1'b0; a_opcode = 3'd0; a_size = 3'd0; a_source = '0; a_address = '0;
    a_prot_privileged = 1'b1; a_mask = '0; a_data = '0;
    #2;
    chk("rst_d_valid",   64'(d_valid),   64'd0);
    chk("rst_d_opcode",  64'(d_opcode),  64'd0);
    chk("rst_d_source",  64'(d_source),  64'd0);
    chk("rst_d_denied",  64'(d_denied),  64'd0);
    chk("rst_d_corrupt", 64'(d_corrupt), 64'd0);
    chk("rst_d_data",    d_data,         64'd0);
    chk("rst_a_ready",   64'(a_ready),   64'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Basic Put/Get, partial writes, boundaries and denials, back to back.
    issue(PF, 3'd3, 1,  A,          8'hFF, 64'h1122334455667788, 1'b1, ACK,  1'b0, 1'b0, 64'h0);
    issue(GT, 3'd3, 2,  A,          8'h00, 64'h0,                1'b1, ACKD, 1'b0, 1'b0, 64'h1122334455667788);
    issue(PP, 3'd3, 3,  A,          8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b1, ACK,  1'b0, 1'b0, 64'h0);
    issue(GT, 3'd3, 4,  A,          8'h00, 64'h0,                1'b1, ACKD, 1'b0, 1'b0, 64'h11223344BBBBBBBB);
    issue(PP, 3'd0, 5,  A + 32'h3,  8'h08, 64'h00000000EE000000, 1'b1, ACK,  1'b0, 1'b0, 64'h0);
    issue(GT, 3'd3, 6,  A,          8'h00, 64'h0,                1'b1, ACKD, 1'b0, 1'b0, 64'h11223344EEBBBBBB);
    issue(GT, 3'd2, 7,  A + 32'h4,  8'h00, 64'h0,                1'b1, ACKD, 1'b0, 1'b0, 64'h11223344EEBBBBBB);
    issue(PF, 3'd3, 8,  TOP,        8'hFF, 64'hDEADBEEFCAFEF00D, 1'b1, ACK,  1'b0, 1'b0, 64'h0);
    issue(GT, 3'd3, 9,  TOP,        8'h00, 64'h0,                1'b1, ACKD, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D);
    issue(GT, 3'd3, 10, OUTR,       8'h00, 64'h0,                1'b1, ACKD, 1'b1, 1'b1, 64'h0);
    issue(GT, 3'd3, 11, BASE - 32'h8, 8'h00, 64'h0,              1'b1, ACKD, 1'b1, 1'b1, 64'h0);
    issue(GT, 3'd4, 12, A,          8'h00, 64'h0,                1'b1, ACKD, 1'b1, 1'b1, 64'h0);
    issue(GT, 3'd2, 13, A + 32'h2,  8'h00, 64'h0,                1'b1, ACKD, 1'b1, 1'b1, 64'h0);
    issue(AR, 3'd3, 14, A,          8'hFF, 64'h0,                1'b1, ACK,  1'b1, 1'b0, 64'h0);
    issue(PF, 3'd3, 15, A + 32'h4,  8'hFF, 64'h0,                1'b1, ACK,  1'b1, 1'b0, 64'h0);
    issue(PF, 3'd3, 16, OUTR,       8'hFF, 64'h0,                1'b1, ACK,  1'b1, 1'b0, 64'h0);
    issue(GT, 3'd3, 17, A,          8'h00, 64'h0,                1'b1, ACKD, 1'b0, 1'b0, 64'h11223344EEBBBBBB);
    drain();

    // Backpressure: response held stable, then drain and refill together.
    d_ready = 1'b0;
    issue(GT, 3'd3, 20, A, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'h11223344EEBBBBBB);
    drive(GT, 3'd3, 21, TOP, 8'h00, 64'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_a_ready",  64'(a_ready),  64'd0);
      chk("stall_d_valid",  64'(d_valid),  64'd1);
      chk("stall_d_source", 64'(d_source), 64'd20);
      chk("stall_d_data",   d_data,        64'h11223344EEBBBBBB);
    end
    @(posedge clock);
    #1 d_ready = 1'b1;
    issue(GT, 3'd3, 21, TOP, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D);
    chk("refill_d_valid",  64'(d_valid),  64'd1);
    chk("refill_d_source", 64'(d_source), 64'd21);
    drain();

    // Sixteen back-to-back Gets: one response per cycle, sources in order.
    dv0 = dv_cycles;
    for (int i = 0; i < 16; i++) begin
      issue(GT, 3'd3, 32 + i, TOP, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D);
    end
    drain();
    chk("b2b_valid_cycles", 64'(dv_cycles - dv0), 64'd16);

    // Unprivileged Put.
`ifdef TL_SRAM_PROT_CHECK_EN
    issue(PF, 3'd3, 40, A, 8'hFF, 64'h0, 1'b0, ACK, 1'b1, 1'b0, 64'h0);
    issue(GT, 3'd3, 41, A, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'h11223344EEBBBBBB);
`else
    issue(PF, 3'd3, 40, A, 8'hFF, 64'h0, 1'b0, ACK, 1'b0, 1'b0, 64'h0);
    issue(GT, 3'd3, 41, A, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'h0);
`endif
    drain();

    // Reset with a pending response drops it; memory survives.
    d_ready = 1'b0;
    issue(GT, 3'd3, 50, TOP, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D);
    chk("pend_d_valid", 64'(d_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_d_valid",  64'(d_valid),  64'd0);
    chk("midrst_d_source", 64'(d_source), 64'd0);
    chk("midrst_d_data",   d_data,        64'd0);
    q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    d_ready = 1'b1;
    issue(GT, 3'd3, 51, TOP, 8'h00, 64'h0, 1'b1, ACKD, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
